adder_intf: RTL and testbench

Registered, flow-controlled binary adder used as the exercised block in the adder verification environment. It accepts operand pairs under a valid/ready handshake, produces the sum, carry-out and signed-overflow flag one cycle later, and holds the result until the consumer accepts it. It also keeps a free-running count of delivered results for scoreboard cross-checks.

---
 rtl/adder_pkg.sv | 25 ++
 rtl/adder_result_reg.sv | 45 ++++
 rtl/adder_intf.sv | 78 +++++++
 tb/tb_adder_intf.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the registered adder and its scoreboard.
package adder_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovf;
  } adder_result_t;

  function automatic adder_result_t add_calc(input logic [DEF_WIDTH-1:0] a,
                                             input logic [DEF_WIDTH-1:0] b,
                                             input logic                 cin);
    logic [DEF_WIDTH:0] full;
    adder_result_t      res;
    full     = {1'b0, a} + {1'b0, b} + {{DEF_WIDTH{1'b0}}, cin};
    res.sum  = full[DEF_WIDTH-1:0];
    res.cout = full[DEF_WIDTH];
    res.ovf  = (a[DEF_WIDTH-1] == b[DEF_WIDTH-1]) && (full[DEF_WIDTH-1] != a[DEF_WIDTH-1]);
    return res;
  endfunction

endpackage

// File: rtl/adder_result_reg.sv
// Single-entry valid/ready holding register; payload type is a parameter.
module adder_result_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic valid_q, valid_d;
  T     data_q,  data_d;

  // No skid buffer: a new entry is taken only when the slot is empty or draining.
  assign in_ready = !rst && (!valid_q || out_ready);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/adder_intf.sv
// Flow-controlled registered adder with sum/carry/overflow and a delivered-result counter.
module adder_intf
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [CNT_W-1:0] res_count
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic [WIDTH:0]   full_sum;
  result_t          res_in;
  result_t          res_out;
  logic             out_valid_int;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  // Overflow: operands agree in sign but the wrapped result does not.
  always_comb begin
    res_in.sum  = full_sum[WIDTH-1:0];
    res_in.cout = full_sum[WIDTH];
    res_in.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
  end

  adder_result_reg #(
    .T (result_t)
  ) u_result_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_in),
    .out_valid (out_valid_int),
    .out_ready (out_ready),
    .out_data  (res_out)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_int && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = out_valid_int;
  assign sum       = res_out.sum;
  assign cout      = res_out.cout;
  assign ovf       = res_out.ovf;
  assign res_count = cnt_q;

endmodule

// File: tb/tb_adder_intf.sv
// Bench for adder_intf: directed and random handshakes against an arithmetic reference model.
module tb_adder_intf;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, cin, out_ready;
  logic [W-1:0] a, b;

  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  logic [15:0]  res_count;

  logic         in_ready_s, out_valid_s, cout_s, ovf_s;
  logic [W-1:0] sum_s;
  logic [2:0]   res_count_s;

  int total = 0;
  int bad   = 0;

  bit          m_valid = 1'b0;
  int          m_sum = 0, m_cout = 0, m_ovf = 0;
  int unsigned m_cnt = 0;

  logic [W-1:0] va [3] = '{4'd7, 4'd7, 4'd15};
  logic [W-1:0] vb [3] = '{4'd9, 4'd1, 4'd15};
  logic         vc [3] = '{1'b0, 1'b0, 1'b1};

  adder_intf #(.WIDTH(W), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .res_count (res_count)
  );

  adder_intf #(.WIDTH(W), .CNT_W(3)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .sum       (sum_s),
    .cout      (cout_s),
    .ovf       (ovf_s),
    .res_count (res_count_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 2**(W-1)) ? v - 2**W : v;
  endfunction

  // One clock: check in_ready, advance the model by the handshake rules, check registered outputs.
  task automatic tick();
    bit exp_rdy, xin, xout;
    int s, ss;
    #1;
    exp_rdy = !rst && (!m_valid || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("in_ready_s", 32'(in_ready_s), 32'(exp_rdy));
    if (rst) begin
      m_valid = 1'b0;
      m_sum   = 0;
      m_cout  = 0;
      m_ovf   = 0;
      m_cnt   = 0;
    end else begin
      xout = m_valid && out_ready;
      xin  = in_valid && exp_rdy;
      if (xout) m_cnt++;
      if (xin) begin
        s       = int'(a) + int'(b) + int'(cin);
        m_sum   = s % (2**W);
        m_cout  = s / (2**W);
        ss      = sgn(int'(a)) + sgn(int'(b)) + int'(cin);
        m_ovf   = (ss > 2**(W-1) - 1 || ss < -(2**(W-1))) ? 1 : 0;
        m_valid = 1'b1;
      end else if (xout) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("sum", 32'(sum), m_sum);
    chk("cout", 32'(cout), m_cout);
    chk("ovf", 32'(ovf), m_ovf);
    chk("res_count", 32'(res_count), m_cnt % 65536);
    chk("out_valid_s", 32'(out_valid_s), 32'(m_valid));
    chk("sum_s", 32'(sum_s), m_sum);
    chk("cout_s", 32'(cout_s), m_cout);
    chk("ovf_s", 32'(ovf_s), m_ovf);
    chk("res_count_s", 32'(res_count_s), m_cnt % 8);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    a = 4'd3; b = 4'd4; cin = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("first_sum", 32'(sum), 32'd7);

    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      tick();
    end

    a = 4'd2; b = 4'd5; cin = 1'b0;
    tick();
    out_ready = 1'b0; a = 4'd1; b = 4'd1;
    repeat (3) tick();
    chk("bp_sum_held", 32'(sum), 32'd7);
    out_ready = 1'b1;
    tick();
    chk("bp_sum_next", 32'(sum), 32'd2);
    in_valid = 1'b0;
    tick();

    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    rst = 1'b0;

    out_ready = 1'b0; in_valid = 1'b1; a = 4'd5; b = 4'd6; cin = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_cnt", 32'(res_count), 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt3", 32'(res_count_s), 32'd1);
    chk("wrap_cnt16", 32'(res_count), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
